// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared types and encodings for the multicycle RISC-V control unit.
// Revision : 1.0  initial release
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    // ALU control codes, matching the ALU's own encodings
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_SLL = 4'b1000;
    localparam logic [3:0] C_ALU_NE  = 4'b0110;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_CMP   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_R      = 7'b0110011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] C_F3_LB  = 3'b000;
    localparam logic [2:0] C_F3_SB  = 3'b000;
    localparam logic [2:0] C_F3_ADD = 3'b000;
    localparam logic [2:0] C_F3_AND = 3'b111;
    localparam logic [2:0] C_F3_SLL = 3'b001;
    localparam logic [2:0] C_F3_ORI = 3'b110;
    localparam logic [2:0] C_F3_BNE = 3'b001;

    localparam logic [1:0] C_RES_ALUOUT = 2'b00;
    localparam logic [1:0] C_RES_MEM    = 2'b01;
    localparam logic [1:0] C_RES_ALURES = 2'b10;

    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_RS1   = 2'b10;

    localparam logic [1:0] C_SRCB_RS2  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM  = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR = 2'b10;

    localparam logic [1:0] C_IMM_I = 2'b00;
    localparam logic [1:0] C_IMM_S = 2'b01;
    localparam logic [1:0] C_IMM_B = 2'b10;

    // True only for the exact encodings this unit can sequence
    function automatic logic is_supported(input logic [31:0] instr);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = instr[6:0];
        f3 = instr[14:12];
        f7 = instr[31:25];
        case (op)
            C_OP_LOAD:   is_supported = (f3 == C_F3_LB);
            C_OP_STORE:  is_supported = (f3 == C_F3_SB);
            C_OP_R:      is_supported = (f7 == 7'b0000000) &&
                                        ((f3 == C_F3_ADD) || (f3 == C_F3_AND) || (f3 == C_F3_SLL));
            C_OP_IMM:    is_supported = (f3 == C_F3_ORI);
            C_OP_BRANCH: is_supported = (f3 == C_F3_BNE);
            default:     is_supported = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational mapping of FSM ALU op class and funct fields to
//            the 4-bit ALU control code.
// Revision : 1.0  initial release
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic [6:0] opcode,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = C_ALU_ADD;
        case (alu_op)
            C_ALUOP_CMP: alu_control = C_ALU_NE;
            C_ALUOP_FUNCT: begin
                if (opcode == C_OP_IMM) begin
                    if (funct3 == C_F3_ORI) alu_control = C_ALU_OR;
                end else begin
                    case (funct3)
                        C_F3_ADD: if (!funct7_5) alu_control = C_ALU_ADD;
                        C_F3_AND: alu_control = C_ALU_AND;
                        C_F3_SLL: alu_control = C_ALU_SLL;
                        default:  alu_control = C_ALU_ADD;
                    endcase
                end
            end
            default: alu_control = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore FSM sequencing the multicycle RISC-V datapath (lb, sb, add,
//            and, sll, ori, bne). Macro ILLEGAL_TRAP_EN enables the TRAP state.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic        illegal_instr
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic [6:0] w_opcode;

    assign w_opcode = instr[6:0];

    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_alu_op    = C_ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        case (r_state)
            FETCH: begin
                alu_src_a  = C_SRCA_PC;
                alu_src_b  = C_SRCB_FOUR;
                result_src = C_RES_ALURES;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = DECODE;
                end
            end
            DECODE: begin
                // Branch target is formed here so BRANCH can load it from ALUOut
                alu_src_a = C_SRCA_OLDPC;
                alu_src_b = C_SRCB_IMM;
                imm_src   = C_IMM_B;
                if (!is_supported(instr)) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = TRAP;
`else
                    w_next = FETCH;
`endif
                end else begin
                    case (w_opcode)
                        C_OP_LOAD, C_OP_STORE: w_next = MEMADR;
                        C_OP_R:                w_next = EXECR;
                        C_OP_IMM:              w_next = EXECI;
                        default:               w_next = BRANCH;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_a = C_SRCA_RS1;
                alu_src_b = C_SRCB_IMM;
                if (w_opcode == C_OP_STORE) begin
                    imm_src = C_IMM_S;
                    w_next  = MEMWRITE;
                end else begin
                    imm_src = C_IMM_I;
                    w_next  = MEMREAD;
                end
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                result_src = C_RES_ALUOUT;
                if (mem_ready) w_next = MEMWB;
            end
            MEMWB: begin
                result_src  = C_RES_MEM;
                w_reg_write = 1'b1;
                w_next      = FETCH;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                result_src  = C_RES_ALUOUT;
                w_mem_write = 1'b1;
                if (mem_ready) w_next = FETCH;
            end
            EXECR: begin
                alu_src_a = C_SRCA_RS1;
                alu_src_b = C_SRCB_RS2;
                w_alu_op  = C_ALUOP_FUNCT;
                w_next    = ALUWB;
            end
            EXECI: begin
                alu_src_a = C_SRCA_RS1;
                alu_src_b = C_SRCB_IMM;
                imm_src   = C_IMM_I;
                w_alu_op  = C_ALUOP_FUNCT;
                w_next    = ALUWB;
            end
            ALUWB: begin
                result_src  = C_RES_ALUOUT;
                w_reg_write = 1'b1;
                w_next      = FETCH;
            end
            BRANCH: begin
                alu_src_a  = C_SRCA_RS1;
                alu_src_b  = C_SRCB_RS2;
                result_src = C_RES_ALUOUT;
                w_alu_op   = C_ALUOP_CMP;
                w_pc_write = ~zero;
                w_next     = FETCH;
            end
            TRAP:    w_next = TRAP;
            default: w_next = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (instr[14:12]),
        .funct7_5    (instr[30]),
        .opcode      (w_opcode),
        .alu_control (alu_control)
    );

    // Reset abandons the instruction: no architectural write in that cycle
    assign pc_write  = w_pc_write  & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign mem_write = w_mem_write & ~reset;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (r_state == TRAP) & ~reset;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Finite-state control unit for the multicycle RISC-V datapath. It decodes the instruction register and sequences the shared ALU and the unified memory port. It drives the ALU's operand selects and 4-bit ALU control code, consumes the ALU zero flag, and owns every architectural write enable. Supported instructions are lb, sb, add, and, sll, ori and bne.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register contents; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result bus
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register and OldPC enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A
- alu_src_b  out  2  00 = rs2 register B, 01 = immediate, 10 = constant 4
- imm_src  out  2  00 = I-type, 01 = S-type, 10 = B-type
- alu_control  out  4  0010 add, 0000 and, 0001 or, 1000 sll, 0110 not-equal compare
- illegal_instr  out  1  unsupported instruction trapped (only with the macro in Configuration)

## Operation
- The state advances on rising clk edges. Outputs are Moore, decoded from the current state. Two exceptions:
  - alu_control also depends on instr.
  - pc_write also depends on zero in BRANCH.
- Strobes not listed for a state are 0.
- Selects not listed for a state take the value 00.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=0010, result_src=10.
  - While mem_ready=0: stay in FETCH with every strobe held at 0.
  - When mem_ready=1: assert ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_control=0010. This precomputes the branch target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - any other opcode → unsupported (see Configuration)
- MEMADR: alu_src_a=10, alu_src_b=01, alu_control=0010.
  - imm_src=00 for lb, then go to MEMREAD.
  - imm_src=01 for sb, then go to MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - mem_write stays asserted until mem_ready=1, then go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00. Go to ALUWB.
  - funct3 000 with funct7 0000000 → 0010
  - funct3 111 → 0000
  - funct3 001 → 1000
- EXECI (ori, funct3 110): alu_src_a=10, alu_src_b=01, imm_src=00, alu_control=0001. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BRANCH (bne, funct3 001): alu_src_a=10, alu_src_b=00, alu_control=0110, result_src=00.
  - pc_write = ~zero, so the branch is taken when rs1 ≠ rs2.
  - Go to FETCH.
- Unsupported instructions are any encoding outside the list above, including a wrong funct3 or funct7 under a supported opcode. They are detected in DECODE.

## Timing
- Reset:
  - Any cycle with reset=1 forces the next state to FETCH.
  - During that cycle, all strobes (pc_write, ir_write, reg_write, mem_write) are forced to 0.
  - illegal_instr clears to 0.
- Reset mid-instruction abandons the instruction. No write strobe fires in the reset cycle.
- Latency with mem_ready tied high:
  - bne: 3 cycles
  - sb, add, and, sll, ori: 4 cycles
  - lb: 5 cycles
- Each memory stall cycle adds exactly one cycle, in FETCH, MEMREAD or MEMWRITE.
- pc_write and ir_write fire in the same cycle as the FETCH completion.
- In BRANCH, the PC loads ALUOut, which holds the target computed in DECODE.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unsupported instruction moves the FSM from DECODE to TRAP.
  - TRAP holds every strobe at 0 and asserts illegal_instr=1 until reset.
- ILLEGAL_TRAP_EN undefined:
  - An unsupported instruction moves the FSM from DECODE to FETCH. It executes as a NOP, since the PC was already advanced in FETCH.
  - illegal_instr is tied to 0.

## Structure
- Package riscv_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, TRAP
  - ALU control code constants, identical to the ALU's encodings
  - opcode and funct3 constants
  - select-value constants for result_src, alu_src_a, alu_src_b and imm_src
- Sub-module alu_decoder is combinational.
  - Inputs: alu_op[1:0] from the FSM (00 add, 01 compare, 10 funct-decoded), funct3, funct7[5], opcode.
  - Output: alu_control.

## Test plan
- Reset held for 2 cycles, then released with mem_ready=1 → strobes 0 during reset; first post-reset cycle in FETCH has ir_write=1 and pc_write=1.
- instr=0x002081B3 (add x3,x1,x2) → EXECR drives alu_control=0010; reg_write=1 in cycle 4 only; total 4 cycles.
- instr=0x00209463 (bne x1,x2,+8):
  - zero=0 in BRANCH → pc_write=1 in cycle 3.
  - zero=1 in BRANCH → pc_write=0.
- instr=0x00008203 (lb x4,0(x1)) with mem_ready low for 2 cycles in MEMREAD → reg_write=1 with result_src=01 in cycle 7.
- instr=0x00F06293 (ori x5,x0,15) → EXECI drives alu_control=0001 and alu_src_b=01.
- instr=0x402081B3 (sub, unsupported):
  - With ILLEGAL_TRAP_EN → illegal_instr=1 from cycle 3, no further strobes until reset.
  - Without the macro → back in FETCH in cycle 3, illegal_instr=0.
